jtag_scan_master: RTL and testbench
===================================

Name: jtag_scan_master

Overview:
Synthesisable, parametrised JTAG scan sequencer. It replaces hand-timed TMS/TDI stimulus with a command-driven engine that walks the IEEE 1149.1 TAP through IR or DR scans of programmable length and returns the captured TDO bits. It sits between a bench or on-chip controller and a TAP-wrapped core (TMS/TDI/TDO pins), in the TCK domain.

Parameters:
MAX_LEN, 64, maximum scan length in bits
LEN_W, 7, width of cmd_len; must be at least clog2(MAX_LEN+1)
TLR_CYCLES, 5, TMS=1 cycles issued after reset to force Test-Logic-Reset

Ports:
TCK  input  1  scan clock, the only clock; everything changes on the rising edge
TRST  input  1  synchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  engine can accept a command
cmd_ir  input  1  1 = IR scan, 0 = DR scan
cmd_len  input  LEN_W  number of bits to shift
cmd_data  input  MAX_LEN  TDI bits, bit 0 shifted first
rsp_valid  output  1  one-cycle response pulse
rsp_data  output  MAX_LEN  captured TDO; bit i holds the i-th bit shifted out; bits at or above len are 0
rsp_err  output  1  command rejected (len 0 or len > MAX_LEN)
TMS  output  1  to TAP
TDI  output  1  to TAP
TDO  input  1  from TAP

Behaviour:
- Reset while TRST=1 at an edge: TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0. All state is discarded, including any scan in progress.
- After TRST drops, the FSM walks TLR -> RTI -> IDLE:
  - TLR: hold TMS=1 for TLR_CYCLES cycles.
  - RTI: drive TMS=0 for 1 cycle.
  - IDLE: cmd_ready=1, TMS=0, TDI=0.
- Handshake: a command is accepted on an edge where cmd_valid and cmd_ready are both 1. cmd_ready drops the next cycle and stays 0 until the cycle after rsp_valid. cmd_data, cmd_ir and cmd_len are latched at acceptance.
- Pin timing: a "cycle" is one TCK period during which TMS/TDI are stable. The TAP acts at the edge that ends that cycle.
- IR scan TMS sequence, starting the cycle after acceptance:
  - 1, 1, 0, 0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
  - Then len shift cycles: TDI = data[i], TMS = 0 except TMS = 1 on the last shift cycle (enters Exit1).
  - Then 1 (Update), then 0 (RTI).
- DR scan: identical, but the prefix is 1, 0, 0.
- Total pin cycles: 6+len for IR, 5+len for DR.
- TDO is sampled at the edge ending each shift cycle into rsp_data[i].
- rsp_valid pulses for 1 cycle, in the cycle after the final RTI cycle. rsp_err=0.
- TDI=0 in all non-shift cycles.
- Error commands (len=0 or len>MAX_LEN):
  - Accepted normally, with no TMS activity.
  - rsp_valid and rsp_err=1 pulse on the next cycle; rsp_data=0.
- rsp_data and rsp_err hold until the next response. rsp_err clears on the next non-error response.
- len=MAX_LEN: all bits used, no overflow. len=1: the single shift cycle carries TMS=1.
- FSM states: TLR, RTI, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RESP.
- Shift counter width is LEN_W. It counts 0..len-1 and never wraps.

Optional Feature:
JTAG_SCAN_CHECK_EN
- When defined, the block adds:
  - cmd_exp (MAX_LEN) and cmd_mask (MAX_LEN) inputs, latched with the command.
  - A rsp_mismatch output (1 bit).
- rsp_mismatch is 1 with rsp_valid when, for some i < len, cmd_mask[i]=1 and the captured TDO bit differs from cmd_exp[i]. It is reset to 0 and is 0 on error responses.
- When not defined, none of these ports exist and the logic is absent.

Test Plan:
- TRST=1 for 2 edges, then 0 -> TMS=1 for exactly 5 cycles, then 0; cmd_ready rises 1 cycle later.
- IR scan, len=2, data=2'b10, TDO tied to TDI via a 2-bit shift-register model -> TMS = 1,1,0,0,0,1,1,0; TDI in shift cycles = 0,1; rsp_valid 9 cycles after acceptance; rsp_err=0.
- DR scan, len=4, data=4'b1001, against the TAP-wrapped core model holding the bypass instruction -> TMS = 1,0,0,0,0,0,1,1,0; rsp_data[0]=0 (bypass capture) and bits 1..3 = 1,0,0.
- cmd_len=0, then cmd_len=65 -> each returns rsp_valid with rsp_err=1 on the next cycle; TMS stays 0.
- Assert TRST in the middle of a len=64 DR shift -> next cycle TMS=1, no rsp_valid, full TLR sequence replays; a following command completes correctly.
- (JTAG_SCAN_CHECK_EN) DR len=8, exp=8'hA5, mask=8'hF0, with TDO producing 8'hA4 -> rsp_mismatch=0; mask=8'h01 -> rsp_mismatch=1.

Source files
------------

// File: rtl/jtag_scan_master.sv
// Command-driven JTAG TAP sequencer: walks IR/DR scans and returns TDO bits.
// Define JTAG_SCAN_CHECK_EN to add expected/mask compare of captured data.
module jtag_scan_master #(
  parameter int MAX_LEN    = 64,
  parameter int LEN_W      = 7,
  parameter int TLR_CYCLES = 5
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_SCAN_CHECK_EN
  input  logic [MAX_LEN-1:0] cmd_exp,
  input  logic [MAX_LEN-1:0] cmd_mask,
  output logic               rsp_mismatch,
`endif
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] TLR_LAST = LEN_W'(TLR_CYCLES - 1);

  localparam logic [3:0] S_TLR     = 4'd0;
  localparam logic [3:0] S_RTI     = 4'd1;
  localparam logic [3:0] S_IDLE    = 4'd2;
  localparam logic [3:0] S_SEL_DR  = 4'd3;
  localparam logic [3:0] S_SEL_IR  = 4'd4;
  localparam logic [3:0] S_CAPTURE = 4'd5;
  localparam logic [3:0] S_SHIFT   = 4'd6;
  localparam logic [3:0] S_EXIT1   = 4'd7;
  localparam logic [3:0] S_UPDATE  = 4'd8;
  localparam logic [3:0] S_RESP    = 4'd9;

  logic [3:0]         state;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_q;
  logic               ir_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] cap;
  logic               cmd_bad;
  logic               last;
  logic               acc;
  logic [IDX_W-1:0]   idx;

  assign cmd_bad = (cmd_len == '0) || (cmd_len > LEN_MAX);
  assign last    = (cnt == len_q - LEN_W'(1));
  assign acc     = (state == S_IDLE) && cmd_valid;
  assign idx     = cnt[IDX_W-1:0];

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state    <= S_TLR;
      cnt      <= '0;
      len_q    <= '0;
      ir_q     <= 1'b0;
      data_q   <= '0;
      cap      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      unique case (state)
        S_TLR: begin
          if (cnt == TLR_LAST) begin
            state <= S_RTI;
            cnt   <= '0;
          end else begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        S_RTI: state <= S_IDLE;
        S_IDLE: begin
          if (acc) begin
            ir_q   <= cmd_ir;
            len_q  <= cmd_len;
            data_q <= cmd_data;
            cap    <= '0;
            cnt    <= '0;
            if (cmd_bad) begin
              state    <= S_RESP;
              rsp_err  <= 1'b1;
              rsp_data <= '0;
            end else begin
              state <= S_SEL_DR;
            end
          end
        end
        S_SEL_DR: state <= ir_q ? S_SEL_IR : S_CAPTURE;
        S_SEL_IR: state <= S_CAPTURE;
        // two TMS=0 cycles: enter Capture, then Capture -> Shift
        S_CAPTURE: begin
          if (cnt == '0) begin
            cnt <= LEN_W'(1);
          end else begin
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          cap[idx] <= TDO;
          if (last) state <= S_EXIT1;
          else      cnt   <= cnt + LEN_W'(1);
        end
        S_EXIT1: state <= S_UPDATE;
        S_UPDATE: begin
          state    <= S_RESP;
          rsp_data <= cap;
          rsp_err  <= 1'b0;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_TLR;
      endcase
    end
  end

`ifdef JTAG_SCAN_CHECK_EN
  logic [MAX_LEN-1:0] exp_q;
  logic [MAX_LEN-1:0] mask_q;
  logic               mis_acc;

  always_ff @(posedge TCK) begin
    if (TRST) begin
      exp_q        <= '0;
      mask_q       <= '0;
      mis_acc      <= 1'b0;
      rsp_mismatch <= 1'b0;
    end else begin
      if (acc) begin
        exp_q   <= cmd_exp;
        mask_q  <= cmd_mask;
        mis_acc <= 1'b0;
        if (cmd_bad) rsp_mismatch <= 1'b0;
      end
      if (state == S_SHIFT && mask_q[idx] && (TDO != exp_q[idx]))
        mis_acc <= 1'b1;
      if (state == S_UPDATE) rsp_mismatch <= mis_acc;
    end
  end
`endif

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    TMS       = 1'b0;
    TDI       = 1'b0;
    unique case (state)
      S_TLR:    TMS = 1'b1;
      S_IDLE:   cmd_ready = 1'b1;
      S_SEL_DR: TMS = 1'b1;
      S_SEL_IR: TMS = 1'b1;
      S_SHIFT: begin
        TMS = last;
        TDI = data_q[idx];
      end
      S_EXIT1:  TMS = 1'b1;
      S_RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master against a small TAP model.
// A 2-bit IR with capture value 01 and a 1-bit bypass DR (or a pattern DR).
module tb_jtag_scan_master;

  logic        TCK;
  logic        TRST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_ir;
  logic [6:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        TMS;
  logic        TDI;
  logic        TDO;
`ifdef JTAG_SCAN_CHECK_EN
  logic [63:0] cmd_exp;
  logic [63:0] cmd_mask;
  logic        rsp_mismatch;
`endif

  int checks = 0;
  int errors = 0;

  jtag_scan_master dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
`ifdef JTAG_SCAN_CHECK_EN
    .cmd_exp      (cmd_exp),
    .cmd_mask     (cmd_mask),
    .rsp_mismatch (rsp_mismatch),
`endif
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  localparam logic [3:0] T_TLR = 4'd0,  T_RTI = 4'd1,  T_SDR = 4'd2;
  localparam logic [3:0] T_CDR = 4'd3,  T_SHD = 4'd4,  T_E1D = 4'd5;
  localparam logic [3:0] T_PAD = 4'd6,  T_E2D = 4'd7,  T_UPD = 4'd8;
  localparam logic [3:0] T_SIR = 4'd9,  T_CIR = 4'd10, T_SHI = 4'd11;
  localparam logic [3:0] T_E1I = 4'd12, T_PAI = 4'd13, T_E2I = 4'd14;
  localparam logic [3:0] T_UPI = 4'd15;

  function automatic logic [3:0] tap_next(input logic [3:0] s,
                                          input logic m);
    case (s)
      T_TLR:   tap_next = m ? T_TLR : T_RTI;
      T_RTI:   tap_next = m ? T_SDR : T_RTI;
      T_SDR:   tap_next = m ? T_SIR : T_CDR;
      T_CDR:   tap_next = m ? T_E1D : T_SHD;
      T_SHD:   tap_next = m ? T_E1D : T_SHD;
      T_E1D:   tap_next = m ? T_UPD : T_PAD;
      T_PAD:   tap_next = m ? T_E2D : T_PAD;
      T_E2D:   tap_next = m ? T_UPD : T_SHD;
      T_UPD:   tap_next = m ? T_SDR : T_RTI;
      T_SIR:   tap_next = m ? T_TLR : T_CIR;
      T_CIR:   tap_next = m ? T_E1I : T_SHI;
      T_SHI:   tap_next = m ? T_E1I : T_SHI;
      T_E1I:   tap_next = m ? T_UPI : T_PAI;
      T_PAI:   tap_next = m ? T_E2I : T_PAI;
      T_E2I:   tap_next = m ? T_UPI : T_SHI;
      default: tap_next = m ? T_SDR : T_RTI;
    endcase
  endfunction

  logic [3:0]  tap = T_TLR;
  logic [1:0]  ir_sr = 2'b00;
  logic [1:0]  ir = 2'b00;
  logic        bp = 1'b0;
  logic [5:0]  pidx = 6'd0;
  logic        use_pat = 1'b0;
  logic [63:0] pat = 64'd0;

  always @(posedge TCK) begin
    tap <= tap_next(tap, TMS);
    if (tap == T_CIR) ir_sr <= 2'b01;
    if (tap == T_SHI) ir_sr <= {TDI, ir_sr[1]};
    if (tap == T_UPI) ir <= ir_sr;
    if (tap == T_CDR) begin
      bp   <= 1'b0;
      pidx <= 6'd0;
    end
    if (tap == T_SHD) begin
      bp   <= TDI;
      pidx <= pidx + 6'd1;
    end
  end

  always_comb begin
    TDO = 1'b0;
    if (tap == T_SHI) TDO = ir_sr[0];
    if (tap == T_SHD) TDO = use_pat ? pat[pidx] : bp;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic reset_seq(input int n);
    logic [6:0] tv;
    logic [6:0] rv;
    logic       any_v;
    TRST = 1'b1;
    repeat (n) @(posedge TCK);
    tv = '0;
    rv = '0;
    any_v = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge TCK);
      if (k == 0) begin
        check("rst_data", rsp_data, 64'd0);
        check("rst_err", {63'd0, rsp_err}, 64'd0);
        TRST = 1'b0;
      end
      tv[k] = TMS;
      rv[k] = cmd_ready;
      any_v |= rsp_valid;
    end
    check("rst_tms", {57'd0, tv}, 64'h1F);
    check("rst_ready", {57'd0, rv}, 64'h40);
    check("rst_novalid", {63'd0, any_v}, 64'd0);
  endtask

  task automatic issue(input logic ir_i, input logic [6:0] len,
                       input logic [63:0] data);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge TCK);
      n++;
    end
    check("ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_ir    = ir_i;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge TCK);
    #1;
    cmd_valid = 1'b0;
    cmd_ir    = ~ir_i;
    cmd_len   = 7'd0;
    cmd_data  = '0;
  endtask

  task automatic collect(output logic [127:0] tv, output logic [127:0] dv,
                         output int lat, output logic busy);
    tv = '0;
    dv = '0;
    lat = 0;
    busy = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge TCK);
      if (rsp_valid) begin
        lat = k;
        return;
      end
      tv[k-1] = TMS;
      dv[k-1] = TDI;
      busy |= cmd_ready;
    end
  endtask

  logic [127:0] tv;
  logic [127:0] dv;
  int           lat;
  logic         busy;

  initial begin
    TRST      = 1'b1;
    cmd_valid = 1'b0;
    cmd_ir    = 1'b0;
    cmd_len   = 7'd0;
    cmd_data  = '0;
`ifdef JTAG_SCAN_CHECK_EN
    cmd_exp  = '0;
    cmd_mask = '0;
`endif
    @(negedge TCK);
    check("rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_tms0", {63'd0, TMS}, 64'd1);
    reset_seq(1);

    // IR scan, len 2, data 10
    issue(1'b1, 7'd2, 64'h2);
    collect(tv, dv, lat, busy);
    check("ir_lat", 64'(lat), 64'd9);
    check("ir_tms", tv[63:0], 64'h63);
    check("ir_tdi", dv[63:0], 64'h20);
    check("ir_data", rsp_data, 64'h1);
    check("ir_err", {63'd0, rsp_err}, 64'd0);
    check("ir_busy", {63'd0, busy}, 64'd0);
    check("ir_tap", {60'd0, tap}, {60'd0, T_RTI});
    check("ir_reg", {62'd0, ir}, 64'h2);

    // DR scan through bypass, len 4, data 1001
    issue(1'b0, 7'd4, 64'h9);
    collect(tv, dv, lat, busy);
    check("dr_lat", 64'(lat), 64'd10);
    check("dr_tms", tv[63:0], 64'hC1);
    check("dr_tdi", dv[63:0], 64'h48);
    check("dr_data", rsp_data, 64'h2);
    check("dr_tap", {60'd0, tap}, {60'd0, T_RTI});

    // rejected lengths
    issue(1'b0, 7'd0, 64'hFF);
    collect(tv, dv, lat, busy);
    check("e0_lat", 64'(lat), 64'd1);
    check("e0_err", {63'd0, rsp_err}, 64'd1);
    check("e0_data", rsp_data, 64'd0);
    @(negedge TCK);
    check("e0_tms", {63'd0, TMS}, 64'd0);
    check("e0_hold", {63'd0, rsp_err}, 64'd1);

    issue(1'b1, 7'd65, 64'hFF);
    collect(tv, dv, lat, busy);
    check("e65_lat", 64'(lat), 64'd1);
    check("e65_err", {63'd0, rsp_err}, 64'd1);
    check("e65_tap", {60'd0, tap}, {60'd0, T_RTI});

    // full-length DR scan
    issue(1'b0, 7'd64, 64'hF0F0_1234_5678_9ABC);
    collect(tv, dv, lat, busy);
    check("d64_lat", 64'(lat), 64'd70);
    check("d64_data", rsp_data, 64'hE1E0_2468_ACF1_3578);
    check("d64_err", {63'd0, rsp_err}, 64'd0);
    check("d64_tms", tv[63:0], 64'h1);

    // reset in the middle of a long shift
    issue(1'b0, 7'd64, 64'h5555_5555_5555_5555);
    repeat (20) @(negedge TCK);
    reset_seq(1);
    check("mid_tap", {60'd0, tap}, {60'd0, T_RTI});

    issue(1'b0, 7'd3, 64'h3);
    collect(tv, dv, lat, busy);
    check("post_lat", 64'(lat), 64'd9);
    check("post_tms", tv[63:0], 64'h61);
    check("post_data", rsp_data, 64'h6);

`ifdef JTAG_SCAN_CHECK_EN
    use_pat  = 1'b1;
    pat      = 64'hA4;
    cmd_exp  = 64'hA5;
    cmd_mask = 64'hF0;
    issue(1'b0, 7'd8, 64'h0);
    cmd_mask = '0;
    collect(tv, dv, lat, busy);
    check("chk_data", rsp_data, 64'hA4);
    check("chk_mis0", {63'd0, rsp_mismatch}, 64'd0);
    cmd_mask = 64'h01;
    issue(1'b0, 7'd8, 64'h0);
    collect(tv, dv, lat, busy);
    check("chk_mis1", {63'd0, rsp_mismatch}, 64'd1);
    issue(1'b0, 7'd0, 64'h0);
    collect(tv, dv, lat, busy);
    check("chk_mis_err", {63'd0, rsp_mismatch}, 64'd0);
    use_pat = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
